booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq_if.sv | 15 +
 rtl/booth_mult_seq.sv | 122 ++++++++++++
 tb/tb_booth_mult_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Start/ready handshake bundle for booth_mult_seq: operands in, status and product out.
interface booth_mult_seq_if #(
  parameter int N = 4
);
  logic                  start;
  logic signed [N-1:0]   a;
  logic signed [N-1:0]   b;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic signed [2*N-1:0] p;

  modport master (output start, a, b, input ready, busy, done, p);
  modport slave  (input start, a, b, output ready, busy, done, p);
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier, one add/sub-and-shift step per clock.
// Define BOOTH_ZERO_SKIP_EN to complete zero-operand multiplies directly on the accepting edge.
module booth_mult_seq #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          clr,
  booth_mult_seq_if.slave bus
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic signed [N:0]     m;
  logic signed [N:0]     acc;
  logic        [N-1:0]   q;
  logic                  q_1;
  logic        [CNT_W-1:0] cnt;
  logic signed [2*N-1:0] p_reg;

  logic signed [N:0]     sum;
  logic signed [N:0]     acc_n;
  logic        [N-1:0]   q_n;
  logic                  last_step;
  logic                  zero_skip;
  logic                  accept;
  logic                  ready;
  logic                  busy;
  logic                  done;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_skip = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  assign last_step = (cnt == CNT_W'(N - 1));
  assign accept    = ready && bus.start;

  // NOTE: every combinational output is given a default first so no path can infer a latch.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_n = {sum[N], sum[N:1]};
    q_n   = {sum[0], q[N-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.start) state_next = zero_skip ? S_DONE : S_CALC;
      S_CALC: if (last_step) state_next = S_DONE;
      S_DONE: begin
        if (bus.start) state_next = zero_skip ? S_DONE : S_CALC;
        else           state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status flags come from the state register only, never from start.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_CALC:  busy  = 1'b1;
      S_DONE:  begin ready = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  // Datapath: an abandoned operation must leave nothing behind, so every register clears.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      p_reg <= '0;
    end else if (accept) begin
      m   <= {bus.a[N-1], bus.a};
      q   <= bus.b;
      acc <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      if (zero_skip) p_reg <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_n;
      q   <= q_n;
      q_1 <= q[0];
      cnt <= cnt + CNT_W'(1);
      if (last_step) p_reg <= {acc_n[N-1:0], q_n};
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.p     = p_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (N=4): expected products queued at accept, checked on done.
module tb_booth_mult_seq;

  localparam int N = 4;
  localparam int FULL_LAT = N + 1;

  logic clk;
  logic clr;
  int   passed;
  int   total;
  logic [2*N-1:0] exp_q[$];

  booth_mult_seq_if #(.N(N)) bus ();

  booth_mult_seq #(.N(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*N-1:0] model(input logic signed [N-1:0] ai,
                                           input logic signed [N-1:0] bi);
    int prod;
    prod = int'(ai) * int'(bi);
    return prod[2*N-1:0];
  endfunction

  function automatic int lat_for(input logic signed [N-1:0] ai,
                                 input logic signed [N-1:0] bi);
    int lat;
    lat = FULL_LAT;
`ifdef BOOTH_ZERO_SKIP_EN
    if (ai == 0 || bi == 0) lat = 1;
`endif
    return lat;
  endfunction

  // Called just after the accepting edge; counts edges until done and checks the scoreboard.
  task automatic wait_done(input string name, input int lat_exp);
    int edges;
    int busy_cnt;
    logic [2*N-1:0] exp;
    edges    = 1;
    busy_cnt = 0;
    while (1) begin
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
      if (edges >= 20) break;
      tick();
      edges++;
    end
    total++;
    if (bus.done !== 1'b1) begin
      $display("FAIL %s_timeout: done not seen after %0d edges", name, edges);
      return;
    end
    passed++;
    total++;
    if (edges !== lat_exp) $display("FAIL %s_latency: got %0d edges, expected %0d", name, edges, lat_exp);
    else passed++;
    total++;
    if (busy_cnt !== lat_exp - 1) $display("FAIL %s_busy: got %0d busy cycles, expected %0d", name, busy_cnt, lat_exp - 1);
    else passed++;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s_scoreboard: done with empty queue, p=%h", name, bus.p);
      return;
    end
    exp = exp_q.pop_front();
    if (bus.p !== exp) $display("FAIL %s_p: got %h, expected %h", name, bus.p, exp);
    else passed++;
  endtask

  task automatic run_mult(input string name, input logic signed [N-1:0] ai,
                          input logic signed [N-1:0] bi);
    bus.start = 1'b1;
    bus.a     = ai;
    bus.b     = bi;
    exp_q.push_back(model(ai, bi));
    tick();
    bus.start = 1'b0;
    bus.a     = ~ai;
    bus.b     = ~bi;
    wait_done(name, lat_for(ai, bi));
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    clr       = 1'b1;
    repeat (2) tick();
    clr = 1'b0;
    tick();
    total++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) $display("FAIL reset_flags: got rbd=%b, expected 100", {bus.ready, bus.busy, bus.done});
    else passed++;
    total++;
    if (bus.p !== 8'h00) $display("FAIL reset_p: got %h, expected 00", bus.p);
    else passed++;
  endtask

  task automatic test_basic();
    logic [2*N-1:0] prev;
    run_mult("basic_3x5", 4'sd3, 4'sd5);
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.p !== 8'h0F) $display("FAIL basic_hold: got done=%b p=%h, expected done=0 p=0f", bus.done, bus.p);
    else passed++;
    // P must keep the old result while the next multiply is in progress.
    prev = bus.p;
    bus.start = 1'b1;
    bus.a     = 4'sd2;
    bus.b     = 4'sd3;
    exp_q.push_back(model(4'sd2, 4'sd3));
    tick();
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.p !== prev) $display("FAIL calc_p_hold: got busy=%b p=%h, expected busy=1 p=%h", bus.busy, bus.p, prev);
    else passed++;
    wait_done("basic_2x3", FULL_LAT - 1);
  endtask

  task automatic test_corners();
    run_mult("corner_m8xm8", -4'sd8, -4'sd8);
    run_mult("corner_m8x7",  -4'sd8,  4'sd7);
    run_mult("corner_m1x1",  -4'sd1,  4'sd1);
    run_mult("corner_7xm8",   4'sd7, -4'sd8);
    for (int i = 0; i < 4; i++) begin
      logic signed [N-1:0] ra;
      logic signed [N-1:0] rb;
      ra = N'($urandom_range(1, 15));
      rb = N'($urandom_range(1, 15));
      run_mult($sformatf("rand%0d", i), ra, rb);
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    bus.a     = 4'sd6;
    bus.b     = -4'sd3;
    exp_q.push_back(model(4'sd6, -4'sd3));
    tick();
    // Start stays high with new operands: ignored during CALC, taken on the DONE-state edge.
    bus.a = 4'sd2;
    bus.b = 4'sd2;
    exp_q.push_back(model(4'sd2, 4'sd2));
    wait_done("b2b_first", FULL_LAT);
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_restart: got busy=%b, expected 1", bus.busy);
    else passed++;
    wait_done("b2b_second", FULL_LAT);
  endtask

  task automatic test_clr_mid();
    bit saw_done;
    bus.start = 1'b1;
    bus.a     = 4'sd5;
    bus.b     = 4'sd5;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    #2;
    clr = 1'b1;
    #1;
    total++;
    if (bus.p !== 8'h00 || {bus.ready, bus.busy, bus.done} !== 3'b100)
      $display("FAIL clr_async: got p=%h rbd=%b, expected p=00 rbd=100", bus.p, {bus.ready, bus.busy, bus.done});
    else passed++;
    tick();
    #2;
    clr = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    total++;
    if (saw_done || bus.ready !== 1'b1) $display("FAIL clr_no_done: got saw_done=%b ready=%b, expected 0/1", saw_done, bus.ready);
    else passed++;
    run_mult("after_clr_2xm2", 4'sd2, -4'sd2);
  endtask

  task automatic test_zero();
    run_mult("zero_0xm7", 4'sd0, -4'sd7);
    run_mult("zero_3x0",  4'sd3,  4'sd0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clr    = 1'b1;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_clr_mid();
    test_zero();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
